// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates one single-ported memory between instruction fetch (I) and load/store (D)
//
// Purpose:
//   Serialises fetch and load/store accesses onto one memory port with a
//   req/ack handshake. D normally wins. A streak limiter forces an I grant
//   after MAX_D_STREAK consecutive D grants made while I was waiting.
//   Optional performance counters are built only when the ARB_PERF_EN macro is defined.
//
// Ports:
//   clock, reset                        rising-edge clock, asynchronous active-high reset
//   i_req/i_addr -> i_rdata/i_ready     fetch request and one-cycle completion
//   i_stall                             i_req & ~i_ready
//   d_req/d_we/d_addr/d_wdata           load/store request
//   d_rdata/d_ready                     load data and one-cycle completion
//   d_stall                             d_req & ~d_ready
//   mem_req/mem_we/mem_addr/mem_wdata   registered memory request, held until mem_ack
//   mem_rdata/mem_ack                   memory response, any latency
//   perf_i_cnt/perf_d_cnt/perf_cfl_cnt  grant and conflict counters (0 without ARB_PERF_EN)
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       perf_i_cnt,
    output logic [31:0]       perf_d_cnt,
    output logic [31:0]       perf_cfl_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_BUSY_I = 3'd1;
    localparam logic [2:0] S_BUSY_D = 3'd2;
    localparam logic [2:0] S_DONE_I = 3'd3;
    localparam logic [2:0] S_DONE_D = 3'd4;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    logic [2:0]        state_q, state_d;
    logic [3:0]        streak_q, streak_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;

    logic grant_d;
    logic grant_i;

    // D wins unless I is waiting and D has already had its full streak.
    assign grant_d = d_req & ~(i_req & (streak_q == STREAK_MAX));
    assign grant_i = ~grant_d & i_req;

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant_d) begin
                    state_d     = S_BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    // Only D grants that actually overtook a waiting I count.
                    if (!i_req) begin
                        streak_d = 4'd0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + 4'd1;
                    end
                end else if (grant_i) begin
                    state_d    = S_BUSY_I;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = i_addr;
                    streak_d   = 4'd0;
                end else begin
                    streak_d = 4'd0;
                end
            end
            S_BUSY_I: begin
                if (mem_ack) begin
                    state_d   = S_DONE_I;
                    mem_req_d = 1'b0;
                    i_rdata_d = mem_rdata;
                    i_ready_d = 1'b1;
                end
            end
            S_BUSY_D: begin
                if (mem_ack) begin
                    state_d   = S_DONE_D;
                    mem_req_d = 1'b0;
                    // A store completes without touching the last load result.
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    d_ready_d = 1'b1;
                end
            end
            S_DONE_I, S_DONE_D: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            streak_q    <= 4'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
        end
    end

`ifdef ARB_PERF_EN
    logic [31:0] perf_i_q, perf_i_d;
    logic [31:0] perf_d_q, perf_d_d;
    logic [31:0] perf_cfl_q, perf_cfl_d;

    always_comb begin
        perf_i_d   = perf_i_q;
        perf_d_d   = perf_d_q;
        perf_cfl_d = perf_cfl_q;
        if (state_q == S_IDLE && grant_d) begin
            perf_d_d = perf_d_q + 32'd1;
        end
        if (state_q == S_IDLE && grant_i) begin
            perf_i_d = perf_i_q + 32'd1;
        end
        if (state_q == S_BUSY_D && i_req) begin
            perf_cfl_d = perf_cfl_q + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_i_q   <= '0;
            perf_d_q   <= '0;
            perf_cfl_q <= '0;
        end else begin
            perf_i_q   <= perf_i_d;
            perf_d_q   <= perf_d_d;
            perf_cfl_q <= perf_cfl_d;
        end
    end

    assign perf_i_cnt   = perf_i_q;
    assign perf_d_cnt   = perf_d_q;
    assign perf_cfl_cnt = perf_cfl_q;
`else
    assign perf_i_cnt   = 32'd0;
    assign perf_d_cnt   = 32'd0;
    assign perf_cfl_cnt = 32'd0;
`endif

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;

    // Pipeline freeze signals; combinational so a stage unfreezes in the ready cycle.
    assign i_stall = i_req & ~i_ready_q;
    assign d_stall = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_ready, i_stall;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ready, d_stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] perf_i_cnt, perf_d_cnt, perf_cfl_cnt;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];
    bit          order_log[$];   // 0 = I completion, 1 = D completion
    int          stamp_log[$];
    int          cyc = 0;
    int          d_ready_seen = 0;
    logic [31:0] last_load_exp = '0;
    logic [31:0] mon_e;

    logic [31:0] mem_store [logic [31:0]];
    int          ack_lat = 0;
    int          wait_cnt = 0;

    mem_port_arbiter dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .perf_i_cnt(perf_i_cnt), .perf_d_cnt(perf_d_cnt), .perf_cfl_cnt(perf_cfl_cnt)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return a ^ 32'hA5A5_1234;
    endfunction

    // Memory model: acks in the cycle where mem_req has been high for ack_lat earlier cycles.
    always @(negedge clock) begin
        mem_ack = 1'b0;
        if (mem_req && !reset) begin
            if (wait_cnt == ack_lat) begin
                mem_ack = 1'b1;
                wait_cnt = 0;
                if (mem_we) begin
                    mem_store[mem_addr] = mem_wdata;
                    mem_rdata = 32'hBAD0_BAD0;
                end else begin
                    mem_rdata = rd(mem_addr);
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Scoreboard: pop the expected result for every completion pulse.
    always @(negedge clock) begin
        if (!reset) begin
            if (i_ready) begin
                checks++;
                if (exp_i.size() == 0) begin
                    failures++;
                    $display("FAIL i_ready_unexpected i_rdata=%h", i_rdata);
                end else begin
                    mon_e = exp_i.pop_front();
                    if (i_rdata !== mon_e) begin
                        failures++;
                        $display("FAIL i_rdata got=%h exp=%h", i_rdata, mon_e);
                    end
                end
                order_log.push_back(1'b0);
                stamp_log.push_back(cyc);
            end
            if (d_ready) begin
                checks++;
                d_ready_seen++;
                if (exp_d.size() == 0) begin
                    failures++;
                    $display("FAIL d_ready_unexpected d_rdata=%h", d_rdata);
                end else begin
                    mon_e = exp_d.pop_front();
                    if (d_rdata !== mon_e) begin
                        failures++;
                        $display("FAIL d_rdata got=%h exp=%h", d_rdata, mon_e);
                    end
                end
                order_log.push_back(1'b1);
                stamp_log.push_back(cyc);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1);
    end

    task automatic apply_reset();
        reset = 1'b1;
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        exp_i.delete();
        exp_d.delete();
        order_log.delete();
        stamp_log.delete();
        last_load_exp = '0;
    endtask

    // Called at posedge+1; leaves at posedge+1 after the ready cycle.
    task automatic drive_i(input logic [31:0] a);
        i_addr = a;
        i_req  = 1'b1;
        exp_i.push_back(rd(a));
        for (int n = 0; n < 200; n++) begin
            @(negedge clock);
            if (i_ready) break;
        end
        if (!i_ready) begin
            checks++;
            failures++;
            $display("FAIL i_timeout addr=%h got_ready=0 exp_ready=1", a);
        end
        @(posedge clock);
        #1;
        i_req = 1'b0;
    endtask

    task automatic drive_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
        if (!we) last_load_exp = rd(a);
        exp_d.push_back(last_load_exp);
        for (int n = 0; n < 200; n++) begin
            @(negedge clock);
            if (d_ready) break;
        end
        if (!d_ready) begin
            checks++;
            failures++;
            $display("FAIL d_timeout addr=%h got_ready=0 exp_ready=1", a);
        end
        @(posedge clock);
        #1;
        d_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] obs[11];
        string       nm[11];
        reset = 1'b1;
        #1;
        obs = '{32'(mem_req), 32'(mem_we), mem_addr, mem_wdata, i_rdata, d_rdata,
                32'(i_ready), 32'(d_ready), perf_i_cnt, perf_d_cnt, perf_cfl_cnt};
        nm  = '{"mem_req", "mem_we", "mem_addr", "mem_wdata", "i_rdata", "d_rdata",
                "i_ready", "d_ready", "perf_i", "perf_d", "perf_cfl"};
        for (int k = 0; k < 11; k++) begin
            checks++;
            if (obs[k] !== 32'd0) begin
                failures++;
                $display("FAIL reset_%s got=%h exp=0", nm[k], obs[k]);
            end
        end
        apply_reset();
    endtask

    task automatic test_i_only();
        ack_lat = 0;
        i_addr = 32'h0040_0000;
        i_req  = 1'b1;
        exp_i.push_back(rd(32'h0040_0000));
        @(negedge clock);
        checks++;
        if (i_stall !== 1'b1 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL i_only_c0 stall=%b mem_req=%b exp stall=1 mem_req=0", i_stall, mem_req);
        end
        @(negedge clock);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0040_0000 ||
            i_stall !== 1'b1 || i_ready !== 1'b0) begin
            failures++;
            $display("FAIL i_only_c1 req=%b we=%b addr=%h stall=%b ready=%b exp 1 0 00400000 1 0",
                     mem_req, mem_we, mem_addr, i_stall, i_ready);
        end
        @(negedge clock);
        checks++;
        if (i_ready !== 1'b1 || i_stall !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL i_only_c2 ready=%b stall=%b mem_req=%b exp 1 0 0", i_ready, i_stall, mem_req);
        end
        @(posedge clock);
        #1;
        i_req = 1'b0;
        @(negedge clock);
        checks++;
        if (i_ready !== 1'b0) begin
            failures++;
            $display("FAIL i_only_pulse ready=%b exp=0", i_ready);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_conflict();
        int  stall_bad = 0;
        bit  done = 0;
        apply_reset();
        ack_lat = 2;
        fork
            drive_d(1'b0, 32'h1001_0004, 32'h0);
            drive_i(32'h0040_0010);
            begin
                for (int n = 0; n < 50 && !done; n++) begin
                    @(negedge clock);
                    if (i_stall !== 1'b1) stall_bad++;
                    if (d_ready) done = 1;
                end
            end
        join
        checks++;
        if (stall_bad != 0 || !done) begin
            failures++;
            $display("FAIL conflict_i_stall low_cycles=%0d d_done=%0b exp 0 1", stall_bad, done);
        end
        checks++;
        if (order_log.size() != 2 || order_log[0] != 1'b1 || order_log[1] != 1'b0) begin
            failures++;
            $display("FAIL conflict_order got_n=%0d first=%0b exp D then I", order_log.size(),
                     order_log.size() > 0 ? order_log[0] : 1'b0);
        end
    endtask

    task automatic test_back_to_back_streak();
        bit exp_order[7] = '{1, 1, 1, 1, 0, 1, 1};
        logic [31:0] ep_i, ep_d, ep_c;
        apply_reset();
        ack_lat = 0;
        fork
            begin
                for (int k = 0; k < 6; k++) drive_d(1'b0, 32'h1001_0100 + 32'(k * 4), 32'h0);
            end
            drive_i(32'h0040_0100);
        join
        checks++;
        if (order_log.size() != 7) begin
            failures++;
            $display("FAIL streak_count got=%0d exp=7", order_log.size());
        end else begin
            for (int k = 0; k < 7; k++) begin
                checks++;
                if (order_log[k] != exp_order[k]) begin
                    failures++;
                    $display("FAIL streak_order idx=%0d got=%0b exp=%0b", k, order_log[k], exp_order[k]);
                end
            end
            for (int k = 1; k < 7; k++) begin
                checks++;
                if (stamp_log[k] - stamp_log[k-1] != 3) begin
                    failures++;
                    $display("FAIL b2b_spacing idx=%0d got=%0d exp=3", k, stamp_log[k] - stamp_log[k-1]);
                end
            end
        end
`ifdef ARB_PERF_EN
        ep_i = 32'd1; ep_d = 32'd6; ep_c = 32'd4;
`else
        ep_i = 32'd0; ep_d = 32'd0; ep_c = 32'd0;
`endif
        checks++;
        if (perf_i_cnt !== ep_i || perf_d_cnt !== ep_d || perf_cfl_cnt !== ep_c) begin
            failures++;
            $display("FAIL perf got i=%0d d=%0d cfl=%0d exp i=%0d d=%0d cfl=%0d",
                     perf_i_cnt, perf_d_cnt, perf_cfl_cnt, ep_i, ep_d, ep_c);
        end
    endtask

    task automatic test_store_delay();
        int hi_cycles = 0;
        int bad = 0;
        int pulses0;
        apply_reset();
        ack_lat = 0;
        drive_d(1'b0, 32'h1001_0020, 32'h0);
        ack_lat = 5;
        pulses0 = d_ready_seen;
        fork
            drive_d(1'b1, 32'h1001_0040, 32'hDEAD_BEEF);
            begin
                for (int n = 0; n < 5 && !mem_req; n++) @(negedge clock);
                for (int n = 0; n < 40 && mem_req; n++) begin
                    hi_cycles++;
                    if (mem_we !== 1'b1 || mem_addr !== 32'h1001_0040 || mem_wdata !== 32'hDEAD_BEEF) bad++;
                    @(negedge clock);
                end
            end
        join
        checks++;
        if (bad != 0 || hi_cycles != 6) begin
            failures++;
            $display("FAIL store_stable bad=%0d hi_cycles=%0d exp bad=0 hi_cycles=6", bad, hi_cycles);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (d_ready_seen - pulses0 != 1) begin
            failures++;
            $display("FAIL store_ready_pulses got=%0d exp=1", d_ready_seen - pulses0);
        end
        checks++;
        if (rd(32'h1001_0040) !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL store_written got=%h exp=deadbeef", rd(32'h1001_0040));
        end
        @(posedge clock);
        #1;
        ack_lat = 0;
        drive_d(1'b0, 32'h1001_0040, 32'h0);
    endtask

    task automatic test_reset_mid();
        logic [31:0] obs[11];
        string       nm[11];
        int          pulses0;
        apply_reset();
        ack_lat = 0;
        drive_d(1'b0, 32'h1001_0008, 32'h0);
        ack_lat = 20;
        d_we   = 1'b0;
        d_addr = 32'h1001_000C;
        d_req  = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("FAIL mid_busy mem_req=%b exp=1", mem_req);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        d_req = 1'b0;
        #1;
        obs = '{32'(mem_req), 32'(mem_we), mem_addr, mem_wdata, i_rdata, d_rdata,
                32'(i_ready), 32'(d_ready), perf_i_cnt, perf_d_cnt, perf_cfl_cnt};
        nm  = '{"mem_req", "mem_we", "mem_addr", "mem_wdata", "i_rdata", "d_rdata",
                "i_ready", "d_ready", "perf_i", "perf_d", "perf_cfl"};
        for (int k = 0; k < 11; k++) begin
            checks++;
            if (obs[k] !== 32'd0) begin
                failures++;
                $display("FAIL mid_reset_%s got=%h exp=0", nm[k], obs[k]);
            end
        end
        apply_reset();
        pulses0 = d_ready_seen;
        repeat (5) @(negedge clock);
        checks++;
        if (d_ready_seen != pulses0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL mid_abandon d_ready_pulses=%0d mem_req=%b exp 0 0", d_ready_seen - pulses0, mem_req);
        end
        @(posedge clock);
        #1;
        ack_lat = 1;
        drive_i(32'h0040_0040);
    endtask

    initial begin
        test_reset();
        test_i_only();
        test_conflict();
        test_back_to_back_streak();
        test_store_delay();
        test_reset_mid();
        repeat (3) @(negedge clock);
        checks++;
        if (exp_i.size() != 0 || exp_d.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain i_left=%0d d_left=%0d exp 0 0", exp_i.size(), exp_d.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
